// File: rtl/lab_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
`timescale 1ns/1ps
package lab_pkg;

  // Converter FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned MAX_BCD4   = 9999;
  localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;

endpackage

// File: rtl/bcd_add3.sv
// Per-nibble correction step of shift-and-add-3: digits >= 5 get +3 so that
// the following left shift carries correctly into the next BCD digit.
`timescale 1ns/1ps
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // 4-bit add; the +3 never needs a carry out for legal digit values.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Inputs above MAX_VAL saturate to MAX_VAL and set the overflow flag.
`timescale 1ns/1ps
module bin_to_bcd_seq
  import lab_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned MAX_VAL  = MAX_BCD4
) (
  input  logic                clk_10mHz,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          bcd_thou,
  output logic [3:0]          bcd_hund,
  output logic [3:0]          bcd_tens,
  output logic [3:0]          bcd_ones
);

  localparam int unsigned W  = BCD_WIDTH + IN_WIDTH;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);

  state_e                state_q, state_d;
  logic [W-1:0]          work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [BCD_WIDTH-1:0]  bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [BCD_WIDTH-1:0]  bcd_fix;
  logic [W-1:0]          shifted;
  logic                  in_ovf;
  logic [IN_WIDTH-1:0]   sat_val;

  // Correct all four digits of the work register in parallel.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work_q[IN_WIDTH + 4*g +: 4]),
      .dout (bcd_fix[4*g +: 4])
    );
  end

  // Corrected BCD field and untouched binary field, shifted left by one.
  // Zero-extension before the compare means narrow inputs never saturate.
  always_comb begin
    shifted = W'({bcd_fix, work_q[IN_WIDTH-1:0], 1'b0});
    in_ovf  = 32'(bin_in) > MAX_VAL;
    sat_val = in_ovf ? IN_WIDTH'(MAX_VAL) : bin_in;
  end

  // Next-state and datapath updates; done defaults low so it only pulses.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d     = {{BCD_WIDTH{1'b0}}, sat_val};
          ovf_pend_d = in_ovf;
          cnt_d      = CW'(IN_WIDTH);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last step lands directly in the result registers.
          bcd_d   = shifted[W-1 -: BCD_WIDTH];
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_10mHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_thou = bcd_q[15:12];
  assign bcd_hund = bcd_q[11:8];
  assign bcd_tens = bcd_q[7:4];
  assign bcd_ones = bcd_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

  localparam int unsigned IN_WIDTH = 14;

  logic                clk_10mHz = 1'b0;
  logic                reset_n   = 1'b0;
  logic                start     = 1'b0;
  logic [IN_WIDTH-1:0] bin_in    = '0;
  logic                busy, done, overflow;
  logic [3:0]          bcd_thou, bcd_hund, bcd_tens, bcd_ones;
  logic [15:0]         digits;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_seq #(
    .IN_WIDTH (IN_WIDTH),
    .MAX_VAL  (9999)
  ) dut (
    .clk_10mHz (clk_10mHz),
    .reset_n   (reset_n),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bcd_thou  (bcd_thou),
    .bcd_hund  (bcd_hund),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones)
  );

  always #50 clk_10mHz = ~clk_10mHz;

  assign digits = {bcd_thou, bcd_hund, bcd_tens, bcd_ones};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal digits of the saturated value, packed as four BCD nibbles.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic convert(input int unsigned v, input string tag);
    int cyc;
    int busy_cnt;
    bit got_done;
    cyc = 0;
    busy_cnt = 0;
    got_done = 0;
    @(negedge clk_10mHz);
    bin_in = v[IN_WIDTH-1:0];
    start  = 1'b1;
    while (!got_done && cyc < 40) begin
      @(negedge clk_10mHz);
      cyc++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) got_done = 1;
    end
    check({tag, " done"}, 32'(got_done), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(IN_WIDTH + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(IN_WIDTH));
    check({tag, " digits"}, 32'(digits), 32'(ref_bcd(v)));
    check({tag, " overflow"}, 32'(overflow), 32'(v > 9999));
    @(negedge clk_10mHz);
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int dones;
    int d1;
    int d2;
    int unsigned v;

    // Reset state.
    #20;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    check("rst digits", 32'(digits), 32'd0);
    @(negedge clk_10mHz);
    reset_n = 1'b1;
    @(negedge clk_10mHz);
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst digits", 32'(digits), 32'd0);

    // Directed values, including saturation and overflow clearing.
    convert(1234, "c1234");
    convert(0, "c0");
    convert(9999, "c9999");
    convert(509, "c0509");
    convert(12000, "c12000");
    convert(42, "c42a");
    convert(16383, "c16383");
    convert(42, "c42b");
    convert(10000, "c10000");

    // Randomised values across the full input range and near the limit.
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) v = $urandom_range(10010, 9990);
      else v = $urandom_range(16383, 0);
      convert(v, $sformatf("rand%0d_%0d", i, v));
    end

    // Start while busy is ignored.
    @(negedge clk_10mHz);
    bin_in = 14'd1234;
    start  = 1'b1;
    cyc = 0;
    dones = 0;
    repeat (40) begin
      @(negedge clk_10mHz);
      cyc++;
      start = (cyc == 5);
      if (cyc == 5) bin_in = 14'd8765;
      if (done) begin
        dones++;
        check("busy_start digits", 32'(digits), 32'h1234);
      end
    end
    check("busy_start dones", 32'(dones), 32'd1);
    check("busy_start idle", 32'(busy), 32'd0);

    // start held high: back-to-back conversions.
    @(negedge clk_10mHz);
    bin_in = 14'd7;
    start  = 1'b1;
    cyc = 0;
    d1 = 0;
    d2 = 0;
    while (d2 == 0 && cyc < 60) begin
      @(negedge clk_10mHz);
      cyc++;
      if (done) begin
        if (d1 == 0) begin
          d1 = cyc;
          check("b2b first digits", 32'(digits), 32'h0007);
          bin_in = 14'd123;
        end else begin
          d2 = cyc;
          check("b2b second digits", 32'(digits), 32'h0123);
          start = 1'b0;
        end
      end
      if (d1 != 0 && cyc == d1 + 7) check("b2b hold digits", 32'(digits), 32'h0007);
    end
    start = 1'b0;
    check("b2b first latency", 32'(d1), 32'd15);
    check("b2b period", 32'(d2 - d1), 32'd15);
    repeat (20) @(negedge clk_10mHz);
    check("b2b stops", 32'(busy), 32'd0);

    // Asynchronous reset mid-conversion.
    @(negedge clk_10mHz);
    bin_in = 14'd4321;
    start  = 1'b1;
    @(negedge clk_10mHz);
    start = 1'b0;
    repeat (6) @(negedge clk_10mHz);
    @(posedge clk_10mHz);
    #20;
    reset_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst ovf", 32'(overflow), 32'd0);
    check("arst digits", 32'(digits), 32'd0);
    repeat (3) @(negedge clk_10mHz);
    reset_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk_10mHz);
      if (done) dones++;
    end
    check("arst no_done", 32'(dones), 32'd0);
    check("arst digits_after", 32'(digits), 32'd0);
    convert(4321, "c4321_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
